// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter feeding the HC-05 rx pin.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Truncating divide; callers must keep the result >= 2.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; power-of-two depth, sync active-low reset.
module bt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bt_uart_tx.sv
// UART 8N1 transmitter with input FIFO; serialises bytes onto tx LSB first.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if a byte is queued
module bt_uart_tx
  import bt_uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         din,
  input  logic                               din_valid,
  output logic                               din_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             baud_wrap;

  assign baud_wrap = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign din_ready = !fifo_full;
  assign fifo_push = din_valid && din_ready;
  // Pop only where the FSM consumes a byte: leaving IDLE, or the STOP wrap.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_wrap));
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  bt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx      <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_dout;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
